// File: rtl/fft_pkg.sv
// Shared types and helpers for the radix-2 DIT FFT address generator.
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } agu_state_t;

  localparam int N_LOG2_DEF = 10;
  localparam int N_LOG2_MAX = 12;

  // Butterfly span (operand distance) of stage s.
  function automatic logic [N_LOG2_MAX-1:0] fft_span(input logic [3:0] s);
    return {{(N_LOG2_MAX-1){1'b0}}, 1'b1} << s;
  endfunction

endpackage

// File: rtl/fft_agu_if.sv
// Start/descriptor handshake bundle between the FFT sequencer and its consumers.
interface fft_agu_if
  import fft_pkg::*;
#(
  parameter int N_LOG2 = N_LOG2_DEF
);
  localparam int SW = $clog2(N_LOG2);

  logic              start;
  logic              out_ready;
  logic              out_valid;
  logic [N_LOG2-1:0] addr_a;
  logic [N_LOG2-1:0] addr_b;
  logic [N_LOG2-2:0] tw_addr;
  logic [SW-1:0]     stage;
  logic              last_in_stage;
  logic              busy;
  logic              done;

  modport master (
    input  start, out_ready,
    output out_valid, addr_a, addr_b, tw_addr, stage, last_in_stage, busy, done
  );

  modport slave (
    output start, out_ready,
    input  out_valid, addr_a, addr_b, tw_addr, stage, last_in_stage, busy, done
  );

endinterface

// File: rtl/fft_agu.sv
// In-place radix-2 DIT FFT address generator: walks all stages, one registered
// butterfly descriptor per handshake, with a drain gap after every stage.
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | issuing descriptor (s, j); holds while out_ready is low
//   DRAIN | gap counter running down so the butterfly pipeline retires
//   DONE  | one-cycle completion pulse
module fft_agu
  import fft_pkg::*;
#(
  parameter int N_LOG2   = N_LOG2_DEF,
  parameter int BFLY_LAT = 4
) (
  input logic       clk,
  input logic       rst_n,
  fft_agu_if.master bus
);
  localparam int SW       = $clog2(N_LOG2);
  localparam int JW       = N_LOG2 - 1;
  localparam int GW       = (BFLY_LAT > 1) ? $clog2(BFLY_LAT) : 1;
  localparam int GAP_LOAD = (BFLY_LAT > 0) ? BFLY_LAT - 1 : 0;
  localparam logic [SW-1:0] S_LAST = SW'(N_LOG2 - 1);

  agu_state_t        state_q, state_d;
  logic [SW-1:0]     s_q, s_d;
  logic [JW-1:0]     j_q, j_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic              stage_end;

  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [N_LOG2-1:0] addr_a_q, addr_a_d;
  logic [N_LOG2-1:0] addr_b_q, addr_b_d;
  logic [JW-1:0]     tw_q, tw_d;

  logic [N_LOG2-1:0] span;
  logic [JW-1:0]     pos;
  logic [JW-1:0]     grp;

  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    j_d       = j_q;
    gap_d     = gap_q;
    stage_end = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          s_d     = '0;
          j_d     = '0;
        end
      end
      RUN: begin
        if (bus.out_ready) begin
          if (j_q != '1) begin
            j_d = j_q + 1'b1;
          end else if (BFLY_LAT > 0) begin
            state_d = DRAIN;
            gap_d   = GW'(GAP_LOAD);
          end else begin
            stage_end = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (gap_q == '0) stage_end = 1'b1;
        else             gap_d     = gap_q - 1'b1;
      end
      DONE: begin
        state_d = IDLE;
        s_d     = '0;
        j_d     = '0;
      end
      default: state_d = IDLE;
    endcase

    // Stage advance happens in the same cycle the RUN/DRAIN exit is taken.
    if (stage_end) begin
      if (s_q != S_LAST) begin
        state_d = RUN;
        s_d     = s_q + 1'b1;
        j_d     = '0;
      end else begin
        state_d = DONE;
      end
    end
  end

  // Descriptor is derived from the next (s, j) so the outputs are pure flops.
  always_comb begin
    span     = N_LOG2'(fft_span(4'(s_d)));
    pos      = JW'(span - 1'b1) & j_d;
    grp      = j_d >> s_d;
    addr_a_d = (({1'b0, grp} << s_d) << 1) | {1'b0, pos};
    addr_b_d = addr_a_d | span;
    tw_d     = pos << (S_LAST - s_d);
    valid_d  = (state_d == RUN);
    last_d   = (state_d == RUN) && (j_d == '1);
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      s_q      <= '0;
      j_q      <= '0;
      gap_q    <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      tw_q     <= '0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      j_q      <= j_d;
      gap_q    <= gap_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      tw_q     <= tw_d;
    end
  end

  assign bus.out_valid     = valid_q;
  assign bus.addr_a        = addr_a_q;
  assign bus.addr_b        = addr_b_q;
  assign bus.tw_addr       = tw_q;
  assign bus.stage         = s_q;
  assign bus.last_in_stage = last_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;

endmodule

// File: tb/tb_fft_agu.sv
// Directed bench for fft_agu: N=8 sequencing, backpressure, zero-latency drain,
// reset abort, start filtering and an N=1024 sweep.
module tb_fft_agu;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  int exp8_a[12]  = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int exp8_b[12]  = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int exp8_tw[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

  fft_agu_if #(.N_LOG2(3))  if8 ();
  fft_agu_if #(.N_LOG2(4))  if16 ();
  fft_agu_if #(.N_LOG2(10)) if1k ();

  fft_agu #(.N_LOG2(3), .BFLY_LAT(2)) u8 (.clk(clk), .rst_n(rst_n), .bus(if8));
  fft_agu #(.N_LOG2(4), .BFLY_LAT(0)) u16 (.clk(clk), .rst_n(rst_n), .bus(if16));
  fft_agu u1k (.clk(clk), .rst_n(rst_n), .bus(if1k));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    if8.start = 1'b0;  if16.start = 1'b0;  if1k.start = 1'b0;
    if8.out_ready = 1'b1; if16.out_ready = 1'b1; if1k.out_ready = 1'b1;
    #12;
    checks++;
    if ({if8.out_valid, if8.addr_a, if8.addr_b, if8.tw_addr, if8.stage,
         if8.last_in_stage, if8.busy, if8.done} !== '0) begin
      errors++;
      $display("FAIL reset_n8 got valid=%b a=%0d b=%0d tw=%0d busy=%b done=%b exp all 0",
               if8.out_valid, if8.addr_a, if8.addr_b, if8.tw_addr, if8.busy, if8.done);
    end
    checks++;
    if ({if16.out_valid, if16.addr_a, if16.addr_b, if16.tw_addr, if16.stage,
         if16.last_in_stage, if16.busy, if16.done} !== '0) begin
      errors++;
      $display("FAIL reset_n16 got valid=%b a=%0d b=%0d exp all 0",
               if16.out_valid, if16.addr_a, if16.addr_b);
    end
    checks++;
    if ({if1k.out_valid, if1k.addr_a, if1k.addr_b, if1k.tw_addr, if1k.stage,
         if1k.last_in_stage, if1k.busy, if1k.done} !== '0) begin
      errors++;
      $display("FAIL reset_n1k got valid=%b a=%0d b=%0d exp all 0",
               if1k.out_valid, if1k.addr_a, if1k.addr_b);
    end
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    checks++;
    if ({if8.busy, if8.out_valid, if16.busy, if16.out_valid, if1k.busy, if1k.out_valid} !== 6'b0) begin
      errors++;
      $display("FAIL idle_after_reset got busy/valid=%b%b%b%b%b%b exp 000000",
               if8.busy, if8.out_valid, if16.busy, if16.out_valid, if1k.busy, if1k.out_valid);
    end
  endtask

  task automatic test_stage_seq();
    logic        ev;
    int          idx;
    logic [10:0] got, exp;
    if8.start = 1'b1;
    tick();
    if8.start = 1'b0;
    for (int c = 1; c <= 21; c++) begin
      ev = (c <= 18) && (((c - 1) % 6) < 4);
      checks++;
      if (if8.out_valid !== ev) begin
        errors++;
        $display("FAIL seq_valid cycle %0d got %b exp %b", c, if8.out_valid, ev);
      end
      if (ev) begin
        idx = ((c - 1) / 6) * 4 + (c - 1) % 6;
        got = {if8.addr_a, if8.addr_b, if8.tw_addr, if8.stage, if8.last_in_stage};
        exp = {3'(exp8_a[idx]), 3'(exp8_b[idx]), 2'(exp8_tw[idx]), 2'(idx / 4), (idx % 4) == 3};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL seq_desc cycle %0d got %h exp %h", c, got, exp);
        end
      end
      checks++;
      if ({if8.busy, if8.done} !== {c <= 19, c == 19}) begin
        errors++;
        $display("FAIL seq_busy_done cycle %0d got %b%b exp %b%b", c, if8.busy, if8.done,
                 c <= 19, c == 19);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] rpat = 64'hB5A3_6C9E_D14F_2A77;
    int          idx = 0;
    int          stalls = 0;
    int          done_c = -1;
    logic        stalled = 1'b0;
    logic [10:0] got, exp;
    if8.start = 1'b1;
    tick();
    if8.start = 1'b0;
    for (int c = 1; c <= 120 && done_c < 0; c++) begin
      if8.out_ready = rpat[c % 64];
      if (stalled) begin
        checks++;
        if (if8.out_valid !== 1'b1) begin
          errors++;
          $display("FAIL bp_valid_hold cycle %0d got %b exp 1", c, if8.out_valid);
        end
      end
      if (if8.out_valid) begin
        checks++;
        if (idx >= 12) begin
          errors++;
          $display("FAIL bp_extra cycle %0d got descriptor %0d exp none", c, idx);
        end else begin
          got = {if8.addr_a, if8.addr_b, if8.tw_addr, if8.stage, if8.last_in_stage};
          exp = {3'(exp8_a[idx]), 3'(exp8_b[idx]), 2'(exp8_tw[idx]), 2'(idx / 4), (idx % 4) == 3};
          if (got !== exp) begin
            errors++;
            $display("FAIL bp_desc cycle %0d idx %0d got %h exp %h", c, idx, got, exp);
          end
        end
        if (if8.out_ready) idx++;
        else               stalls++;
      end
      stalled = if8.out_valid && !if8.out_ready;
      if (if8.done) done_c = c;
      tick();
    end
    if8.out_ready = 1'b1;
    checks++;
    if (done_c != 19 + stalls) begin
      errors++;
      $display("FAIL bp_done_cycle got %0d exp %0d", done_c, 19 + stalls);
    end
    checks++;
    if (idx != 12) begin
      errors++;
      $display("FAIL bp_count got %0d exp 12", idx);
    end
  endtask

  task automatic test_lat0();
    int          idx;
    logic        chk;
    logic [10:0] got, exp;
    if16.start = 1'b1;
    tick();
    if16.start = 1'b0;
    for (int c = 1; c <= 34; c++) begin
      checks++;
      if ({if16.out_valid, if16.busy, if16.done} !== {c <= 32, c <= 33, c == 33}) begin
        errors++;
        $display("FAIL lat0_ctrl cycle %0d got %b%b%b exp %b%b%b", c, if16.out_valid,
                 if16.busy, if16.done, c <= 32, c <= 33, c == 33);
      end
      if (c <= 32) begin
        idx = c - 1;
        checks++;
        if ({if16.last_in_stage, if16.stage} !== {(idx % 8) == 7, 2'(idx / 8)}) begin
          errors++;
          $display("FAIL lat0_tags idx %0d got %b/%0d exp %b/%0d", idx, if16.last_in_stage,
                   if16.stage, (idx % 8) == 7, idx / 8);
        end
        chk = 1'b1;
        case (idx)
          0:       exp = {4'd0,  4'd1,  3'd0};
          7:       exp = {4'd14, 4'd15, 3'd0};
          9:       exp = {4'd1,  4'd3,  3'd4};
          15:      exp = {4'd13, 4'd15, 3'd4};
          16:      exp = {4'd0,  4'd4,  3'd0};
          31:      exp = {4'd7,  4'd15, 3'd7};
          default: begin chk = 1'b0; exp = '0; end
        endcase
        got = {if16.addr_a, if16.addr_b, if16.tw_addr};
        if (chk) begin
          checks++;
          if (got !== exp) begin
            errors++;
            $display("FAIL lat0_desc idx %0d got %h exp %h", idx, got, exp);
          end
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    int   done_c = -1;
    logic leak = 1'b0;
    if8.start = 1'b1;
    tick();
    if8.start = 1'b0;
    repeat (7) tick();
    checks++;
    if ({if8.out_valid, if8.stage} !== {1'b1, 2'd1}) begin
      errors++;
      $display("FAIL rm_precond got valid=%b stage=%0d exp 1/1", if8.out_valid, if8.stage);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({if8.out_valid, if8.addr_a, if8.addr_b, if8.tw_addr, if8.stage,
         if8.last_in_stage, if8.busy, if8.done} !== '0) begin
      errors++;
      $display("FAIL rm_async got valid=%b a=%0d b=%0d tw=%0d stage=%0d busy=%b exp all 0",
               if8.out_valid, if8.addr_a, if8.addr_b, if8.tw_addr, if8.stage, if8.busy);
    end
    repeat (4) begin
      tick();
      if (if8.done || if8.busy) leak = 1'b1;
    end
    rst_n = 1'b1;
    repeat (3) begin
      tick();
      if (if8.done || if8.busy) leak = 1'b1;
    end
    checks++;
    if (leak !== 1'b0) begin
      errors++;
      $display("FAIL rm_no_done got busy/done activity exp none");
    end
    if8.start = 1'b1;
    tick();
    if8.start = 1'b0;
    checks++;
    if ({if8.out_valid, if8.addr_a, if8.addr_b, if8.tw_addr, if8.stage} !==
        {1'b1, 3'd0, 3'd1, 2'd0, 2'd0}) begin
      errors++;
      $display("FAIL rm_restart got valid=%b a=%0d b=%0d tw=%0d stage=%0d exp 1 0 1 0 0",
               if8.out_valid, if8.addr_a, if8.addr_b, if8.tw_addr, if8.stage);
    end
    for (int c = 2; c <= 25; c++) begin
      tick();
      if (if8.done) begin
        done_c = c;
        break;
      end
    end
    checks++;
    if (done_c != 19) begin
      errors++;
      $display("FAIL rm_done_cycle got %0d exp 19", done_c);
    end
    tick();
  endtask

  task automatic test_start_busy();
    int          cc;
    int          idx;
    logic        ev;
    logic [10:0] got, exp;
    if8.start = 1'b1;
    tick();
    for (int c = 1; c <= 42; c++) begin
      if8.start = (c == 2) || (c == 5) || (c >= 17 && c <= 20);
      cc = (c <= 20) ? c : c - 20;
      ev = (cc <= 18) && (((cc - 1) % 6) < 4);
      checks++;
      if ({if8.out_valid, if8.busy, if8.done} !== {ev, cc <= 19, cc == 19}) begin
        errors++;
        $display("FAIL sb_ctrl cycle %0d got %b%b%b exp %b%b%b", c, if8.out_valid,
                 if8.busy, if8.done, ev, cc <= 19, cc == 19);
      end
      if (ev) begin
        idx = ((cc - 1) / 6) * 4 + (cc - 1) % 6;
        got = {if8.addr_a, if8.addr_b, if8.tw_addr, if8.stage, if8.last_in_stage};
        exp = {3'(exp8_a[idx]), 3'(exp8_b[idx]), 2'(exp8_tw[idx]), 2'(idx / 4), (idx % 4) == 3};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL sb_desc cycle %0d got %h exp %h", c, got, exp);
        end
      end
      tick();
    end
    if8.start = 1'b0;
  endtask

  task automatic test_full_sweep();
    bit   seen[1024];
    int   n_desc = 0, busy_cnt = 0, stage_cnt = 0, in_stage = 0;
    int   twmax = 0, done_c = -1, stages_done = 0;
    foreach (seen[i]) seen[i] = 1'b0;
    if1k.start = 1'b1;
    tick();
    if1k.start = 1'b0;
    for (int c = 1; c <= 6000 && done_c < 0; c++) begin
      if (if1k.busy && !if1k.done) busy_cnt++;
      if (if1k.out_valid) begin
        checks++;
        if (if1k.addr_b !== if1k.addr_a + (10'd1 << if1k.stage)) begin
          errors++;
          $display("FAIL sweep_span desc %0d got a=%0d b=%0d stage=%0d", n_desc,
                   if1k.addr_a, if1k.addr_b, if1k.stage);
        end
        checks++;
        if (seen[if1k.addr_a] || seen[if1k.addr_b]) begin
          errors++;
          $display("FAIL sweep_dup desc %0d got a=%0d b=%0d already touched exp fresh",
                   n_desc, if1k.addr_a, if1k.addr_b);
        end
        if (!seen[if1k.addr_a]) stage_cnt++;
        if (!seen[if1k.addr_b]) stage_cnt++;
        seen[if1k.addr_a] = 1'b1;
        seen[if1k.addr_b] = 1'b1;
        checks++;
        if ({if1k.last_in_stage, if1k.stage} !== {in_stage == 511, 4'(n_desc / 512)}) begin
          errors++;
          $display("FAIL sweep_tags desc %0d got %b/%0d exp %b/%0d", n_desc,
                   if1k.last_in_stage, if1k.stage, in_stage == 511, n_desc / 512);
        end
        if (if1k.stage == 4'd9 && int'(if1k.tw_addr) > twmax) twmax = int'(if1k.tw_addr);
        n_desc++;
        in_stage++;
        if (in_stage == 512) begin
          checks++;
          if (stage_cnt != 1024) begin
            errors++;
            $display("FAIL sweep_cover stage %0d got %0d exp 1024", stages_done, stage_cnt);
          end
          stages_done++;
          in_stage  = 0;
          stage_cnt = 0;
          foreach (seen[i]) seen[i] = 1'b0;
        end
      end
      if (if1k.done) begin
        done_c = c;
        checks++;
        if (if1k.busy !== 1'b1) begin
          errors++;
          $display("FAIL sweep_done_busy got %b exp 1", if1k.busy);
        end
      end
      tick();
    end
    checks++;
    if (done_c != 5161) begin
      errors++;
      $display("FAIL sweep_done_cycle got %0d exp 5161", done_c);
    end
    checks++;
    if (n_desc != 5120 || stages_done != 10) begin
      errors++;
      $display("FAIL sweep_count got %0d/%0d exp 5120/10", n_desc, stages_done);
    end
    checks++;
    if (busy_cnt != 5160) begin
      errors++;
      $display("FAIL sweep_busy got %0d exp 5160", busy_cnt);
    end
    checks++;
    if (twmax != 511) begin
      errors++;
      $display("FAIL sweep_twmax got %0d exp 511", twmax);
    end
    checks++;
    if (if1k.busy !== 1'b0) begin
      errors++;
      $display("FAIL sweep_idle got busy=%b exp 0", if1k.busy);
    end
  endtask

  initial begin
    test_reset();
    test_stage_seq();
    test_backpressure();
    test_lat0();
    test_reset_mid();
    test_start_busy();
    test_full_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_agu.md
# fft_agu

In-place radix-2 DIT FFT address generator and sequencer. On `start`, it walks all log2(N) stages and issues one butterfly descriptor per handshake: two data-memory addresses, a twiddle index and stage tags. It sits directly upstream of the butterfly datapath and of `twiddle_rom`. `tw_addr` drives `twiddle_rom.addr`, and `twiddle_rom` is instantiated with `ADDR_WIDTH = N_LOG2-1`, so it holds N/2 entries.

## Interface
- `N_LOG2`, default 10: log2 of FFT size N; legal range 2..12.
- `BFLY_LAT`, default 4: butterfly pipeline depth in cycles. This is the number of idle cycles inserted after each stage before the next stage's descriptors are issued (RAW hazard drain).
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: begin a transform; sampled only in IDLE.
- `out_ready`  in  1: downstream accepts the current descriptor.
- `out_valid`  out  1: descriptor outputs valid.
- `addr_a`  out  N_LOG2: upper butterfly operand address.
- `addr_b`  out  N_LOG2: lower operand address; always equals `addr_a + span`.
- `tw_addr`  out  N_LOG2-1: twiddle index k.
- `stage`  out  $clog2(N_LOG2): current stage s.
- `last_in_stage`  out  1: current descriptor is j = N/2-1.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse when the transform completes.

## Operation
- Symbols:
  - L = N_LOG2.
  - j is the butterfly index, 0..N/2-1.
  - span = 1<<s.
  - pos = j & (span-1).
  - group = j >> s.
- Address equations:
  - `addr_a` = (group << (s+1)) | pos.
  - `addr_b` = `addr_a` | span.
  - `tw_addr` = pos << (L-1-s).
- All arithmetic is unsigned and truncated to the port width; no carry ever exceeds the width.
- States:
  - IDLE: `start` → RUN with s=0, j=0. `start` is ignored in every other state.
  - RUN: `out_valid`=1. On `out_valid && out_ready`:
    - j < N/2-1: j increments.
    - j = N/2-1 and BFLY_LAT>0: → DRAIN, gap counter loads BFLY_LAT-1.
    - j = N/2-1 and BFLY_LAT=0: → NEXT.
  - DRAIN: `out_valid`=0. Gap counter decrements each cycle; at 0 → NEXT.
  - NEXT (zero-time decision, folded into the DRAIN/RUN exit):
    - s < L-1: s increments, j clears, → RUN.
    - otherwise → DONE.
  - DONE: `done`=1 for exactly one cycle, then → IDLE.
- Registered outputs:
  - All outputs are registered.
  - While `out_valid`=1 and `out_ready`=0, every descriptor output holds stable (no change, no skip).
  - `out_valid` never drops without a handshake except on reset.
- Reset, asserted at any time including mid-transform:
  - All outputs go to 0 and state goes to IDLE immediately.
  - Counters s, j and gap clear.
  - No `done` is emitted for the aborted transform.

## Timing
- Reset values: `out_valid`, `addr_a`, `addr_b`, `tw_addr`, `stage`, `last_in_stage`, `busy` and `done` are all 0.
- Latency:
  - `start` high at edge 0 (IDLE) gives `busy`=1 and `out_valid`=1 with j=0 after edge 0 (cycle 1).
  - `start` held high over multiple cycles launches exactly one transform.
- Throughput: one descriptor per cycle while `out_ready`=1.
- With `out_ready` held high, the transform lasts L·(N/2) + L·BFLY_LAT cycles of `busy`.
  - The last BFLY_LAT cycles are the final drain.
  - `done` asserts in the following cycle, with `busy` still 1.
  - `busy` falls together with `done` at the next edge.
- Back-to-back transforms: `start` asserted in the cycle after `done` (IDLE) starts a new transform. There is no minimum idle gap.
- `last_in_stage` is asserted concurrently with the j = N/2-1 descriptor of each stage.

## Structure
- Package `fft_pkg`:
  - Typedef `agu_state_t` with values IDLE, RUN, DRAIN, DONE.
  - Default `N_LOG2`.
  - Helper function `fft_span(s)`.
- No sub-module: one FSM, a j counter, an s counter and a gap counter, in a single `always_ff` with combinational address derivation registered into the outputs.
- The shift `pos << (L-1-s)` is implemented as a barrel shift. For L ≤ 12 this is acceptable timing-wise at the target clock.

## Test plan
- **Stage sequence, N=8.** Setup: N_LOG2=3, BFLY_LAT=2, `out_ready`=1, `start` pulse.
  - Stage 0, (a,b,tw): (0,1,0), (2,3,0), (4,5,0), (6,7,0).
  - Stage 1: (0,2,0), (1,3,2), (4,6,0), (5,7,2).
  - Stage 2: (0,4,0), (1,5,1), (2,6,2), (3,7,3).
  - Required: exactly 2 invalid cycles after each stage; `done` in cycle 19 (start at cycle 0).
- **Backpressure.** Same config, `out_ready` toggled pseudo-randomly.
  - Required: identical descriptor sequence, outputs stable while stalled, no duplicates or drops.
  - Required: `done` delayed by exactly the number of stall cycles.
- **BFLY_LAT=0, N_LOG2=4.** Required: 32 consecutive valid cycles with no gaps; `done` in the cycle after the 32nd handshake.
- **Reset mid-operation.** Assert `rst_n`=0 during stage 1 of N=8.
  - Required: all outputs 0 asynchronously, no `done`.
  - Required: a subsequent `start` restarts at s=0, j=0, output (0,1,0).
- **Start while busy.** Pulse `start` during RUN and during DRAIN.
  - Required: no effect, sequence unchanged.
  - Required: `start` held high through `done` launches the next transform exactly one cycle after `done`.
- **N=1024 full sweep.** Default parameters.
  - Required: 5120 descriptors; every address 0..1023 touched exactly once per stage.
  - Required: `tw_addr` max 511 in stage 9; `busy` lasts 5160 cycles.
